// File: rtl/lsp_quant_pkg.sv
// Shared constants, state encoding and helpers for the scalar LSP codebook search.
// LSP_CB_SEARCH_SQERR_EN selects the squared-error metric (one extra pipeline stage).
package lsp_quant_pkg;

  localparam int N      = 32;
  localparam int IDXW   = 4;
  localparam int NUM_CB = 10;

  localparam logic [N-1:0] ERR_MAX = 32'hFFFF_FFFF;

  localparam int CB_SIZE [0:NUM_CB-1] = '{16, 16, 16, 16, 16, 16, 16, 8, 8, 4};

`ifdef LSP_CB_SEARCH_SQERR_EN
  localparam int ERR_LAT = 1;
`else
  localparam int ERR_LAT = 0;
`endif

  // Cycles spent in DRAIN waiting for the last entry to reach the comparator.
  localparam int DRAIN_CYC = 1 + ERR_LAT;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  function automatic logic [3:0] clamp_sel(input logic [3:0] sel);
    return (sel > 4'd9) ? 4'd9 : sel;
  endfunction

  function automatic logic [IDXW-1:0] last_addr(input logic [3:0] sel);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CB; i++) begin
      if (sel == 4'(i)) r = IDXW'(CB_SIZE[i] - 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/lsp_err_calc.sv
// Error metric for one codebook entry: |cb - target| saturated, or under
// LSP_CB_SEARCH_SQERR_EN a registered (cb - target)^2 in Q.16 with saturation.
module lsp_err_calc
  import lsp_quant_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [IDXW-1:0] in_idx,
  input  logic [N-1:0]    cb,
  input  logic [N-1:0]    target,
  output logic            out_valid,
  output logic [IDXW-1:0] out_idx,
  output logic [N-1:0]    err
);

  logic signed [N:0] diff;
  logic [N:0]        mag;

  assign diff = $signed({cb[N-1], cb}) - $signed({target[N-1], target});
  assign mag  = diff[N] ? (N+1)'(-diff) : (N+1)'(diff);

`ifdef LSP_CB_SEARCH_SQERR_EN
  logic [2*N+1:0]  sq;
  logic [N-1:0]    sq_sat;
  logic            valid_q, valid_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N-1:0]    err_q, err_d;

  assign sq     = {{(N+1){1'b0}}, mag} * {{(N+1){1'b0}}, mag};
  // Drop 16 fraction bits of the Q.32 product; anything above bit N+15 overflows.
  assign sq_sat = (|sq[2*N+1:N+16]) ? ERR_MAX : sq[N+15:16];

  always_comb begin
    valid_d = in_valid;
    idx_d   = in_idx;
    err_d   = sq_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      err_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign err       = err_q;
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ rst;
  assign out_valid      = in_valid;
  assign out_idx        = in_idx;
  assign err            = mag[N] ? ERR_MAX : mag[N-1:0];
`endif

endmodule

// File: rtl/lsp_cb_search.sv
// Scalar LSP quantiser search: sweeps one codebook through cbselect and returns the
// nearest entry. LSP_CB_SEARCH_SQERR_EN switches to squared error (+1 cycle latency).
module lsp_cb_search
  import lsp_quant_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      cb_sel_in,
  input  logic [N-1:0]    target,
  output logic [3:0]      cb_select,
  output logic [IDXW-1:0] cb_addr,
  input  logic [N-1:0]    cb_data,
  output logic            busy,
  output logic            done,
  output logic [IDXW-1:0] best_index,
  output logic [N-1:0]    best_error
);

  state_e          state_q, state_d;
  logic [3:0]      sel_q, sel_d;
  logic [IDXW-1:0] addr_q, addr_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [N-1:0]    tgt_q, tgt_d;
  logic [1:0]      drain_q, drain_d;

  logic            s1_valid_q, s1_valid_d;
  logic [IDXW-1:0] s1_idx_q, s1_idx_d;
  logic [N-1:0]    s1_data_q, s1_data_d;

  logic [IDXW-1:0] run_idx_q, run_idx_d;
  logic [N-1:0]    run_err_q, run_err_d;
  logic [IDXW-1:0] best_index_q, best_index_d;
  logic [N-1:0]    best_error_q, best_error_d;

  logic            e_valid;
  logic [IDXW-1:0] e_idx;
  logic [N-1:0]    e_err;

  lsp_err_calc u_err (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid_q),
    .in_idx    (s1_idx_q),
    .cb        (s1_data_q),
    .target    (tgt_q),
    .out_valid (e_valid),
    .out_idx   (e_idx),
    .err       (e_err)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    last_d       = last_q;
    tgt_d        = tgt_q;
    drain_d      = drain_q;
    s1_valid_d   = 1'b0;
    s1_idx_d     = s1_idx_q;
    s1_data_d    = s1_data_q;
    run_idx_d    = run_idx_q;
    run_err_d    = run_err_q;
    best_index_d = best_index_q;
    best_error_d = best_error_q;

    // Entry 0 seeds the running minimum; strict less-than keeps the lowest index on ties.
    if (e_valid && ((e_idx == '0) || (e_err < run_err_q))) begin
      run_idx_d = e_idx;
      run_err_d = e_err;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d   = clamp_sel(cb_sel_in);
          last_d  = last_addr(clamp_sel(cb_sel_in));
          tgt_d   = target;
          addr_d  = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        s1_valid_d = 1'b1;
        s1_idx_d   = addr_q;
        s1_data_d  = cb_data;
        if (addr_q == last_q) begin
          drain_d = '0;
          state_d = ST_DRAIN;
        end else begin
          addr_d = addr_q + IDXW'(1);
        end
      end
      ST_DRAIN: begin
        // The last compare resolves in this cycle, so publish its outcome directly.
        if (drain_q == 2'(DRAIN_CYC - 1)) begin
          best_index_d = run_idx_d;
          best_error_d = run_err_d;
          state_d      = ST_FINISH;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      addr_q       <= '0;
      last_q       <= '0;
      tgt_q        <= '0;
      drain_q      <= '0;
      s1_valid_q   <= 1'b0;
      s1_idx_q     <= '0;
      s1_data_q    <= '0;
      run_idx_q    <= '0;
      run_err_q    <= '0;
      best_index_q <= '0;
      best_error_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      addr_q       <= addr_d;
      last_q       <= last_d;
      tgt_q        <= tgt_d;
      drain_q      <= drain_d;
      s1_valid_q   <= s1_valid_d;
      s1_idx_q     <= s1_idx_d;
      s1_data_q    <= s1_data_d;
      run_idx_q    <= run_idx_d;
      run_err_q    <= run_err_d;
      best_index_q <= best_index_d;
      best_error_q <= best_error_d;
    end
  end

  assign cb_select  = sel_q;
  assign cb_addr    = addr_q;
  assign busy       = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_FINISH);
  assign best_index = best_index_q;
  assign best_error = best_error_q;

endmodule

// File: tb/tb_lsp_cb_search.sv
// Randomised self-checking bench for lsp_cb_search with a stub cbselect and a
// behavioural nearest-entry model; honours LSP_CB_SEARCH_SQERR_EN.
module tb_lsp_cb_search;

`ifdef LSP_CB_SEARCH_SQERR_EN
  localparam int SQ = 1;
`else
  localparam int SQ = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  cb_sel_in, cb_select;
  logic [31:0] target, cb_data, best_error;
  logic [3:0]  cb_addr, best_index;
  logic        busy, done;

  always #5 clk = ~clk;

  lsp_cb_search dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cb_sel_in  (cb_sel_in),
    .target     (target),
    .cb_select  (cb_select),
    .cb_addr    (cb_addr),
    .cb_data    (cb_data),
    .busy       (busy),
    .done       (done),
    .best_index (best_index),
    .best_error (best_error)
  );

  // Stub cbselect: 0 = ramp (entry i = i.0), 1 = max positive everywhere, 2 = random table.
  logic [1:0]  mode;
  logic [31:0] rnd_mem [0:255];

  always_comb begin
    case (mode)
      2'd0:    cb_data = {12'h0, cb_addr, 16'h0};
      2'd1:    cb_data = 32'h7FFF_FFFF;
      default: cb_data = rnd_mem[{cb_select, cb_addr}];
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int cb_size(input int sel);
    int s;
    s = (sel > 9) ? 9 : sel;
    if (s <= 6) return 16;
    if (s <= 8) return 8;
    return 4;
  endfunction

  function automatic logic [31:0] entry(input int sel, input int i);
    logic [7:0] a;
    a = 8'(sel * 16 + i);
    case (mode)
      2'd0:    return 32'(i) << 16;
      2'd1:    return 32'h7FFF_FFFF;
      default: return rnd_mem[a];
    endcase
  endfunction

  function automatic logic [31:0] err_of(input logic [31:0] c, input logic [31:0] t);
    int                cs, ts;
    longint            d;
    longint unsigned   p;
    cs = c;
    ts = t;
    d  = longint'(cs) - longint'(ts);
    if (d < 0) d = -d;
    if (SQ != 0) begin
      p = longint'(d);
      p = (p * p) >> 16;
      return (p > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
    end
    return (d > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : d[31:0];
  endfunction

  task automatic model(input int sel_raw, input logic [31:0] tgt,
                       output int bi, output logic [31:0] be);
    int          s;
    logic [31:0] e;
    s  = (sel_raw > 9) ? 9 : sel_raw;
    bi = 0;
    be = 32'h0;
    for (int i = 0; i < cb_size(s); i++) begin
      e = err_of(entry(s, i), tgt);
      if (i == 0 || e < be) begin
        bi = i;
        be = e;
      end
    end
  endtask

  // Expected-behaviour state shared between driver (negedge) and monitor (posedge+1).
  bit          chk_en = 1'b0;
  bit          active = 1'b0;
  int          exp_S, exp_m, exp_idx;
  logic [31:0] exp_err;
  int          held_idx  = 0;
  logic [31:0] held_err  = 32'h0;
  int          sel_hold  = 0;
  int          addr_hold = 0;

  always @(posedge clk) begin
    bit dexp, bexp;
    int aexp;
    cyc++;
    #1;
    if (chk_en) begin
      dexp = active && (cyc == exp_S + exp_m + 2 + SQ);
      bexp = active && (cyc > exp_S) && (cyc < exp_S + exp_m + 2 + SQ);
      if (dexp) begin
        held_idx = exp_idx;
        held_err = exp_err;
      end
      if (active && cyc > exp_S && cyc <= exp_S + exp_m) aexp = cyc - exp_S - 1;
      else aexp = addr_hold;
      check("done", 32'(done), 32'(dexp));
      check("busy", 32'(busy), 32'(bexp));
      check("best_index", 32'(best_index), 32'(held_idx));
      check("best_error", best_error, held_err);
      check("cb_select", 32'(cb_select), 32'(sel_hold));
      check("cb_addr", 32'(cb_addr), 32'(aexp));
      if (dexp) active = 1'b0;
    end
  end

  // Call at a negedge: asserts start for this cycle, returns at the next negedge.
  task automatic start_search(input logic [3:0] sel, input logic [31:0] tgt);
    cb_sel_in = sel;
    target    = tgt;
    start     = 1'b1;
    model(int'(sel), tgt, exp_idx, exp_err);
    exp_S     = cyc;
    exp_m     = cb_size(int'(sel));
    sel_hold  = (sel > 4'd9) ? 9 : int'(sel);
    addr_hold = exp_m - 1;
    active    = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    cb_sel_in = 4'($urandom);
    target    = $urandom;
  endtask

  // Returns at the negedge of the done cycle; latency is -1 on timeout.
  task automatic wait_done(output int lat);
    int k;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      check("done_timeout", 32'(done), 32'd1);
      lat = -1;
    end else begin
      lat = cyc - exp_S;
    end
    $display("search sel=%0d target=%h -> index=%0d error=%h latency=%0d",
             sel_hold, target, best_index, best_error, lat);
  endtask

  initial begin
    int lat;
    int r;
    logic [3:0]  s;
    logic [31:0] t;

    rst = 1'b1; start = 1'b0; cb_sel_in = '0; target = '0; mode = 2'd0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) rnd_mem[i] = rnd_mem[i-1];
      else rnd_mem[i] = $urandom;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_best_error", best_error, 32'h0);
    check("reset_cb_addr", 32'(cb_addr), 32'd0);
    chk_en = 1'b1;
    @(negedge clk);

    // Ramp codebook, target 5.25
    start_search(4'd0, 32'h0005_4000);
    wait_done(lat);
    check("t1_index", 32'(best_index), 32'd5);
    check("t1_error", best_error, (SQ != 0) ? 32'h0000_1000 : 32'h0000_4000);
    check("t1_latency", 32'(lat), 32'(18 + SQ));
    // start in FINISH cycle is ignored; the cycle after is accepted
    start = 1'b1;
    cb_sel_in = 4'd3;
    @(negedge clk);
    start_search(4'd9, 32'h000A_0000);
    wait_done(lat);
    check("t2_index", 32'(best_index), 32'd3);
    check("t2_error", best_error, (SQ != 0) ? 32'h0031_0000 : 32'h0007_0000);
    check("t2_latency", 32'(lat), 32'(6 + SQ));
    @(negedge clk);

    // Tie between entries 2 and 3
    start_search(4'd0, 32'h0002_8000);
    wait_done(lat);
    check("t3_index", 32'(best_index), 32'd2);
    check("t3_error", best_error, (SQ != 0) ? 32'h0000_4000 : 32'h0000_8000);
    @(negedge clk);

    // Out-of-range select clamps to codebook 9
    start_search(4'd13, 32'hFFFF_0000);
    @(negedge clk);
    check("t4_select", 32'(cb_select), 32'd9);
    wait_done(lat);
    check("t4_index", 32'(best_index), 32'd0);
    check("t4_error", best_error, 32'h0001_0000);
    @(negedge clk);

    // Re-pulsed start during a search is ignored
    start_search(4'd1, 32'h0007_0000);
    repeat (2) @(negedge clk);
    start = 1'b1;
    cb_sel_in = 4'd9;
    target = 32'h0;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("t5_index", 32'(best_index), 32'd7);
    check("t5_latency", 32'(lat), 32'(18 + SQ));
    @(negedge clk);

    // Reset mid-search: no done, everything back to zero, next start works
    start_search(4'd2, 32'h0004_0000);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    active = 1'b0; held_idx = 0; held_err = 32'h0; sel_hold = 0; addr_hold = 0;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_index", 32'(best_index), 32'd0);
    check("t6_rst_select", 32'(cb_select), 32'd0);
    repeat (20) @(negedge clk);
    start_search(4'd8, 32'h0006_0000);
    wait_done(lat);
    check("t6_after_index", 32'(best_index), 32'd6);
    check("t6_after_latency", 32'(lat), 32'(10 + SQ));
    @(negedge clk);

    // Error extreme saturates
    mode = 2'd1;
    start_search(4'd0, 32'h8000_0000);
    wait_done(lat);
    check("t7_index", 32'(best_index), 32'd0);
    check("t7_error", best_error, 32'hFFFF_FFFF);
    @(negedge clk);

    // Randomised searches against the model
    mode = 2'd2;
    for (int n = 0; n < 40; n++) begin
      s = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 2);
      t = rnd_mem[{(s > 4'd9) ? 4'd9 : s, 4'($urandom_range(0, 3))}];
      if (r == 0) t = $urandom;
      else if (r == 2) t = t + 32'($urandom_range(0, 32'h0003_0000)) - 32'h0001_8000;
      start_search(s, t);
      wait_done(lat);
      check("rand_latency", 32'(lat), 32'(cb_size(int'(s)) + 2 + SQ));
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
